pulse_train_gen: RTL and testbench

- Generates a programmed number of square pulses with a direction flag (step/dir).
- It is the transmit end of the pulse-counting interface: drives motor-driver step inputs, and feeds the pulse counter in closed-loop self-test.
- Software or a control FSM loads count, half-period and direction, then issues start; the block reports busy, remaining pulses and done.

---
 rtl/pulse_train_gen.sv | 123 ++++++++++++
 tb/tb_pulse_train_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Step/dir pulse train generator: emits a latched number of 50%-duty pulses and reports busy/remaining/done.
// Define PULSE_GEN_CONTINUOUS_EN to make a count=0 start run indefinitely until abort or reset.
module pulse_train_gen #(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dir,
    input  logic [COUNT_WIDTH-1:0]  count,
    input  logic [PERIOD_WIDTH-1:0] half_period,
    output logic                    pulse_out,
    output logic                    dir_out,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  remaining
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t                  state, state_nxt;
    logic [PERIOD_WIDTH-1:0] h_q;
    logic [PERIOD_WIDTH-1:0] phase_cnt;
    logic [PERIOD_WIDTH-1:0] reload;
    logic                    accept;
    logic                    phase_end;
    logic                    cont_start;
    logic                    cont_q;
    logic                    pulse_d, busy_d, done_d;

    function automatic logic [PERIOD_WIDTH-1:0] clamp_half(input logic [PERIOD_WIDTH-1:0] hp);
        return (hp == '0) ? PERIOD_WIDTH'(1) : hp;
    endfunction

    assign accept    = (state == IDLE) && start && !abort;
    assign phase_end = (phase_cnt == '0);
    assign reload    = accept ? clamp_half(half_period) : h_q;

`ifdef PULSE_GEN_CONTINUOUS_EN
    assign cont_start = (count == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cont_q <= 1'b0;
        else if (accept)
            cont_q <= cont_start;
    end
`else
    assign cont_start = 1'b0;
    assign cont_q     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (count != '0 || cont_start) ? HIGH : DONE;
            end
            HIGH: begin
                if (abort)
                    state_nxt = DONE;
                else if (phase_end)
                    state_nxt = LOW;
            end
            LOW: begin
                if (abort)
                    state_nxt = DONE;
                else if (phase_end)
                    state_nxt = (remaining != '0 || cont_q) ? HIGH : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they are glitch-free flops.
    always_comb begin
        pulse_d = (state_nxt == HIGH);
        busy_d  = (state_nxt == HIGH) || (state_nxt == LOW);
        done_d  = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir_out   <= 1'b0;
            remaining <= '0;
        end else begin
            pulse_out <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
            if (accept) begin
                dir_out   <= dir;
                remaining <= count;
            end else if (state == HIGH && phase_end && !abort && !cont_q) begin
                remaining <= remaining - COUNT_WIDTH'(1);
            end
        end
    end

    // Phase counter reloads on every phase entry and only counts down while nonzero.
    always_ff @(posedge clk) begin
        if (accept)
            h_q <= clamp_half(half_period);
        if (state_nxt != state && (state_nxt == HIGH || state_nxt == LOW))
            phase_cnt <= reload - PERIOD_WIDTH'(1);
        else if ((state == HIGH || state == LOW) && !phase_end)
            phase_cnt <= phase_cnt - PERIOD_WIDTH'(1);
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed and randomized trains checked against a cycle-index arithmetic model.
module tb_pulse_train_gen;

    localparam int CW = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dir = 1'b0;
    logic [CW-1:0] count = '0;
    logic [PW-1:0] half_period = '0;
    logic          pulse_out, dir_out, busy, done;
    logic [CW-1:0] remaining;

    int   total = 0;
    int   bad = 0;
    int   lb = 0;
    logic pulse_prev = 1'b0;

    pulse_train_gen #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
        .count(count), .half_period(half_period),
        .pulse_out(pulse_out), .dir_out(dir_out), .busy(busy), .done(done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Loopback up/down pulse counter fed by pulse_out/dir_out.
    always @(negedge clk) begin
        if (pulse_out && !pulse_prev)
            lb <= dir_out ? lb - 1 : lb + 1;
        pulse_prev <= pulse_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int p, input int b, input int dn,
                             input int rem, input int d);
        chk({tag, ".pulse_out"}, int'(pulse_out), p);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), dn);
        chk({tag, ".remaining"}, int'(remaining), rem);
        chk({tag, ".dir_out"}, int'(dir_out), d);
    endtask

    // Pulses whose high phase has ended by train cycle k (k=1 is the first high cycle).
    function automatic int pulses_done(input int k, input int h);
        return (k - 1) / (2 * h) + ((((k - 1) % (2 * h)) >= h) ? 1 : 0);
    endfunction

    task automatic run_train(input int n, input int h_in, input bit d, input int abort_at,
                             input int rst_at, input int mid_start, input bit start_in_done);
        int h, len, last, lb0, exp_rem;
        bit cont, cut;
        h = (h_in == 0) ? 1 : h_in;
        cont = 1'b0;
`ifdef PULSE_GEN_CONTINUOUS_EN
        cont = (n == 0);
`endif
        len  = cont ? 0 : 2 * h * n;
        cut  = cont || (abort_at > 0 && abort_at <= len);
        last = cut ? abort_at : len;
        lb0  = lb;

        count = CW'(n); half_period = PW'(h_in); dir = d; start = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            check_out("train", (((k - 1) % (2 * h)) < h) ? 1 : 0, 1, 0,
                      cont ? 0 : n - pulses_done(k, h), int'(d));
            count = CW'($urandom);
            half_period = PW'($urandom_range(0, 7));
            dir = 1'($urandom);
            start = (k == mid_start);
            if (k == abort_at) abort = 1'b1;
            if (k == rst_at) begin
                start = 1'b0;
                rst = 1'b1;
                tick();
                check_out("rst", 0, 0, 0, 0, 0);
                rst = 1'b0;
                tick();
                check_out("post_rst", 0, 0, 0, 0, 0);
                return;
            end
            tick();
        end
        start = 1'b0;
        exp_rem = (cont || !cut) ? 0 : n - pulses_done(last, h);
        check_out("done", 0, 0, 1, exp_rem, int'(d));
        abort = 1'b0;
        start = start_in_done;
        tick();
        start = 1'b0;
        check_out("idle", 0, 0, 0, exp_rem, int'(d));
        tick();
        check_out("idle2", 0, 0, 0, exp_rem, int'(d));
        if (!cut) chk("loopback", lb - lb0, d ? -n : n);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        check_out("reset", 0, 0, 0, 0, 0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        check_out("reset_release", 0, 0, 0, 0, 0);

        run_train(3, 2, 1'b1, 0, 0, 0, 1'b0);
        run_train(2, 0, 1'b0, 0, 0, 0, 1'b1);
        run_train(5, 3, 1'b0, 8, 0, 3, 1'b0);
`ifdef PULSE_GEN_CONTINUOUS_EN
        run_train(0, 1, 1'b1, 115, 0, 0, 1'b0);
`else
        run_train(0, 2, 1'b1, 0, 0, 0, 1'b0);
`endif
        run_train(4, 2, 1'b1, 0, 7, 0, 1'b0);
        run_train(1, 1, 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int n, hp, hh, ab, ms;
            bit d;
            n  = $urandom_range(1, 6);
            hp = $urandom_range(0, 4);
            hh = (hp == 0) ? 1 : hp;
            d  = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * hh * n) : 0;
            ms = $urandom_range(1, 3);
            run_train(n, hp, d, ab, 0, ms, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
